// File: rtl/capture_readback_fifo.sv
// capture_readback_fifo
//   Collects DUT result samples into an in-order buffer while armed. A
//   simulation harness drains the buffer through a valid/ready read port.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   arm         pulse: flush buffer, clear flags, enter CAPTURE
//   stop        pulse: leave CAPTURE for DONE (ignored in other states)
//   in_valid    DUT sample present this cycle
//   in_data     DUT sample
//   rd_ready    reader accepts rd_data this cycle
//   rd_valid    buffer non-empty
//   rd_data     oldest buffered sample, 0 when empty (first-word fall-through)
//   level       entries held, 0..DEPTH
//   state_o     IDLE=0, CAPTURE=1, DONE=2
//   done        state_o == DONE
//   overflow    sticky, at least one sample dropped since last arm
//   drop_count  dropped samples since last arm, saturating at 0xFFFF
//
// Handshake: a sample leaves the buffer on a clock edge where
// rd_valid && rd_ready are both high (and arm is low); rd_data stays
// stable while rd_valid=1 and rd_ready=0.

module capture_readback_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arm,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] level,
  output logic [1:0]       state_o,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic             r_overflow;
  logic [15:0]      r_drop_count;

  logic w_capturing;
  logic w_pop;
  logic w_write;
  logic w_drop;

  // arm flushes everything, so any pop/write in the arm cycle is discarded.
  assign w_capturing = (r_state == S_CAPTURE) && in_valid && !arm;
  assign w_pop       = rd_valid && rd_ready && !arm;
  // A simultaneous pop frees a slot, so a full buffer still accepts the sample.
  assign w_write     = w_capturing && ((r_level != FULL_LEVEL) || w_pop);
  assign w_drop      = w_capturing && (r_level == FULL_LEVEL) && !w_pop;

  assign rd_valid   = (r_level != '0);
  assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign level      = r_level;
  assign state_o    = r_state;
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // Storage carries no reset: contents are only observable through rd_data,
  // which is gated by level.
  always_ff @(posedge clock) begin
    if (w_write) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (arm) begin
      r_state <= S_CAPTURE;
    end else if (stop && r_state == S_CAPTURE) begin
      r_state <= S_DONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (arm) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_readback_fifo.sv
// Testbench for capture_readback_fifo. Inputs change 1 ns after a rising
// edge and outputs are sampled there too, away from the active edge.

module tb_capture_readback_fifo;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] level;
  logic [1:0]    state_o;
  logic          done;
  logic          overflow;
  logic [15:0]   drop_count;

  capture_readback_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .level      (level),
    .state_o    (state_o),
    .done       (done),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int           m_state;
  bit           m_ovf;
  int           m_drops;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [W-1:0] exp_front();
    return (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then let the DUT take the same edge.
  task automatic step();
    bit pop;
    pop = (exp_q.size() > 0) && rd_ready && !arm;
    if (arm) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_state = 1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_state == 1 && in_valid) begin
        if (exp_q.size() < D) exp_q.push_back(in_data);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (m_state == 1 && stop) m_state = 2;
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic a, input logic s, input logic v,
                       input logic [W-1:0] d, input logic r);
    arm = a; stop = s; in_valid = v; in_data = d; rd_ready = r;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, '0, 0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({level, rd_valid, rd_data, state_o, done, overflow, drop_count} !==
        {CW'(0), 1'b0, W'(0), 2'd0, 1'b0, 1'b0, 16'd0}) begin
      $display("FAIL reset: level=%0d rd_valid=%0b rd_data=%h state=%0d done=%0b ovf=%0b drops=%0d, want all 0",
               level, rd_valid, rd_data, state_o, done, overflow, drop_count);
    end else n_pass++;
  endtask

  task automatic test_basic();
    apply_reset();
    drive(1, 0, 0, '0, 0); step();
    for (int i = 1; i <= 5; i++) begin drive(0, 0, 1, W'(i), 0); step(); end
    drive(0, 1, 0, '0, 0); step();
    n_total++;
    if (level !== CW'(5) || done !== 1'b1) begin
      $display("FAIL basic_fill: level=%0d done=%0b, want 5 1", level, done);
    end else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, '0, 1);
      n_total++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i)) begin
        $display("FAIL basic_read[%0d]: rd_valid=%0b rd_data=%h, want 1 %h", i, rd_valid, rd_data, W'(i));
      end else n_pass++;
      step();
    end
    drive(0, 0, 0, '0, 0);
    n_total++;
    if ({level, rd_valid, done, overflow} !== {CW'(0), 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL basic_end: level=%0d rd_valid=%0b done=%0b ovf=%0b, want 0 0 1 0",
               level, rd_valid, done, overflow);
    end else n_pass++;
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, '0, 0); step();
    for (int i = 0; i < 20; i++) begin drive(0, 0, 1, W'(32'h10 + i), 0); step(); end
    drive(0, 0, 0, '0, 0);
    n_total++;
    if ({level, overflow, drop_count} !== {CW'(16), 1'b1, 16'd4}) begin
      $display("FAIL overflow_state: level=%0d ovf=%0b drops=%0d, want 16 1 4", level, overflow, drop_count);
    end else n_pass++;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, '0, 1);
      n_total++;
      if (rd_data !== W'(32'h10 + i)) begin
        $display("FAIL overflow_read[%0d]: rd_data=%h want %h", i, rd_data, W'(32'h10 + i));
      end else n_pass++;
      step();
    end
    drive(0, 0, 0, '0, 0);
    n_total++;
    if (rd_valid !== 1'b0 || level !== CW'(0)) begin
      $display("FAIL overflow_empty: rd_valid=%0b level=%0d, want 0 0", rd_valid, level);
    end else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [W-1:0] last;
    last = W'($urandom());
    drive(1, 0, 0, '0, 0); step();
    for (int i = 0; i < D; i++) begin drive(0, 0, 1, W'($urandom()), 0); step(); end
    drive(0, 0, 1, last, 1); step();
    drive(0, 0, 0, '0, 0);
    n_total++;
    if ({level, overflow, drop_count} !== {CW'(16), 1'b0, 16'd0}) begin
      $display("FAIL full_pop: level=%0d ovf=%0b drops=%0d, want 16 0 0", level, overflow, drop_count);
    end else n_pass++;
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 0, '0, 1);
      n_total++;
      if (rd_data !== exp_front()) begin
        $display("FAIL full_pop_read[%0d]: rd_data=%h want %h", i, rd_data, exp_front());
      end else n_pass++;
      if (i == D - 1) begin
        n_total++;
        if (rd_data !== last) begin
          $display("FAIL full_pop_last: rd_data=%h want %h", rd_data, last);
        end else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_wrap_backpressure();
    int sent = 0, got = 0, cycles = 0;
    bit tog = 1'b0;
    bit hold_chk;
    logic [W-1:0] held;
    logic [W-1:0] sent_q[$];
    drive(1, 0, 0, '0, 0); step();
    while ((sent < 40 || got < 40) && cycles < 400) begin
      logic v;
      logic [W-1:0] d;
      v = (sent < 40) && (cycles % 2 == 0);
      d = W'($urandom());
      drive(0, 0, v, d, tog);
      if (v) begin sent++; sent_q.push_back(d); end
      if (rd_valid && tog) begin
        n_total++;
        if (rd_data !== sent_q[got]) begin
          $display("FAIL wrap_read[%0d]: rd_data=%h want %h", got, rd_data, sent_q[got]);
        end else n_pass++;
        got++;
      end
      hold_chk = (exp_q.size() > 0) && !tog;
      held     = exp_front();
      step();
      if (hold_chk) begin
        n_total++;
        if (rd_data !== held) begin
          $display("FAIL wrap_stall: rd_data=%h want %h", rd_data, held);
        end else n_pass++;
      end
      tog = ~tog;
      cycles++;
    end
    drive(0, 0, 0, '0, 0);
    n_total++;
    if (got != 40 || drop_count !== 16'd0 || rd_valid !== 1'b0) begin
      $display("FAIL wrap_end: got=%0d drops=%0d rd_valid=%0b, want 40 0 0", got, drop_count, rd_valid);
    end else n_pass++;
  endtask

  task automatic test_ignored_priority();
    apply_reset();
    drive(0, 0, 1, 32'hDEAD, 0); step();
    drive(0, 0, 0, '0, 0);
    n_total++;
    if (level !== CW'(0) || state_o !== 2'd0) begin
      $display("FAIL idle_ignore: level=%0d state=%0d, want 0 0", level, state_o);
    end else n_pass++;
    drive(1, 1, 0, '0, 0); step();
    drive(0, 0, 0, '0, 0);
    n_total++;
    if (state_o !== 2'd1) begin
      $display("FAIL arm_stop: state=%0d want 1", state_o);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, W'($urandom()), 0); step(); end
    drive(0, 1, 0, '0, 0); step();
    drive(0, 0, 1, 32'hBEEF, 0); step();
    drive(0, 0, 0, '0, 0);
    n_total++;
    if (state_o !== 2'd2 || level !== CW'(3) || drop_count !== 16'd0) begin
      $display("FAIL done_hold: state=%0d level=%0d drops=%0d, want 2 3 0", state_o, level, drop_count);
    end else n_pass++;
    drive(1, 0, 0, '0, 1); step();
    drive(0, 0, 0, '0, 0);
    n_total++;
    if ({level, rd_valid, state_o} !== {CW'(0), 1'b0, 2'd1}) begin
      $display("FAIL rearm_done: level=%0d rd_valid=%0b state=%0d, want 0 0 1", level, rd_valid, state_o);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1), W'($urandom()), $urandom_range(0, 2) != 0);
      step();
      n_total++;
      if ({level, rd_valid, rd_data, state_o, done, overflow, drop_count} !==
          {CW'(exp_q.size()), exp_q.size() > 0, exp_front(), 2'(m_state), m_state == 2, m_ovf, 16'(m_drops)}) begin
        $display("FAIL random[%0d]: level=%0d rd_data=%h state=%0d ovf=%0b drops=%0d, want %0d %h %0d %0b %0d",
                 c, level, rd_data, state_o, overflow, drop_count,
                 exp_q.size(), exp_front(), m_state, m_ovf, m_drops);
      end else n_pass++;
    end
    drive(0, 0, 0, '0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, '0, 0); step();
    for (int i = 0; i < 6; i++) begin drive(0, 0, 1, W'(i + 100), 0); step(); end
    drive(0, 0, 0, '0, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({level, rd_valid, state_o, overflow} !== {CW'(0), 1'b0, 2'd0, 1'b0}) begin
      $display("FAIL reset_mid: level=%0d rd_valid=%0b state=%0d ovf=%0b, want 0 0 0 0",
               level, rd_valid, state_o, overflow);
    end else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_wrap_backpressure();
    test_ignored_priority();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
